inst_queue: RTL and testbench

- Instruction buffer between fetch_instruction and the decode stage.
- Captures each valid fetched word with its address in a DEPTH-entry circular FIFO and presents the oldest entry to decode.
- Decouples fetch from decode stalls, back-pressures fetch when full, and discards all contents on branch redirect.

---
 rtl/inst_queue_pkg.sv | 9 +
 rtl/inst_queue.sv | 72 +++++++
 tb/tb_inst_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths and constants for the fetch / instruction-queue / decode slice.
package inst_queue_pkg;

    localparam int          IQ_WORD  = 32;
    localparam int          IQ_ADDR  = 16;
    localparam int          IQ_DEPTH = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

endpackage

// File: rtl/inst_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry circular FIFO of
// {instruction, address} that presents the oldest entry to decode.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int WORD  = IQ_WORD,
    parameter int ADDR  = IQ_ADDR,
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            v_i,
    input  logic [WORD-1:0] inst_i,
    input  logic [ADDR-1:0] pc_i,
    output logic            stall_o,
    input  logic            flush,
    output logic            v_o,
    output logic [WORD-1:0] inst_o,
    output logic [ADDR-1:0] pc_o,
    input  logic            stall_i
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [WORD-1:0]  inst_q [DEPTH];
    logic [ADDR-1:0]  pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    // Status is derived from registered count only, so stall_i never reaches stall_o.
    assign stall_o = (count == FULL);
    assign v_o     = (count != '0);

    assign push = v_i & ~stall_o & ~flush;
    assign pop  = v_o & ~stall_i & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; stale entries are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= inst_i;
            pc_q[wr_ptr]   <= pc_i;
        end
    end

    assign inst_o = v_o ? inst_q[rd_ptr] : WORD'(INST_NOP);
    assign pc_o   = v_o ? pc_q[rd_ptr]   : '0;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_inst_queue;

    logic        clk;
    logic        reset;
    logic        v_i;
    logic [31:0] inst_i;
    logic [15:0] pc_i;
    logic        stall_o;
    logic        flush;
    logic        v_o;
    logic [31:0] inst_o;
    logic [15:0] pc_o;
    logic        stall_i;

    int vectors;
    int miscompares;

    logic [47:0] mq [$];

    inst_queue dut (
        .clk     (clk),
        .reset   (reset),
        .v_i     (v_i),
        .inst_i  (inst_i),
        .pc_i    (pc_i),
        .stall_o (stall_o),
        .flush   (flush),
        .v_o     (v_o),
        .inst_o  (inst_o),
        .pc_o    (pc_o),
        .stall_i (stall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of {inst, pc}, capacity 4.
    always @(posedge clk) begin
        if (reset) begin
            if (flush) begin
                mq.delete();
            end else begin
                automatic bit do_push = v_i && (mq.size() < 4);
                automatic bit do_pop  = (mq.size() > 0) && !stall_i;
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back({inst_i, pc_i});
            end
        end
    end

    always @(negedge reset) mq.delete();

    always @(negedge clk) begin
        check("model_v",     {47'd0, v_o},     {47'd0, mq.size() != 0});
        check("model_stall", {47'd0, stall_o}, {47'd0, mq.size() == 4});
        check("model_head",  {inst_o, pc_o},   (mq.size() != 0) ? mq[0] : 48'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [15:0] pc,
                         input logic si, input logic fl);
        v_i = v; inst_i = inst; pc_i = pc; stall_i = si; flush = fl;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_v",     {47'd0, v_o},     48'd0);
        check("rst_stall", {47'd0, stall_o}, 48'd0);
        check("rst_head",  {inst_o, pc_o},   48'd0);
        reset = 1'b1;

        // basic flow
        drive(1'b1, 32'h11111111, 16'h0000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("basic_v",    {47'd0, v_o},   48'd1);
        check("basic_head", {inst_o, pc_o}, {32'h11111111, 16'h0000});
        tick();
        check("basic_empty", {47'd0, v_o}, 48'd0);

        // fill to full, fifth word refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hA0 + i, 16'(i), 1'b1, 1'b0);
            tick();
        end
        check("full_stall", {47'd0, stall_o}, 48'd1);
        check("full_head",  {inst_o, pc_o},   {32'hA0, 16'h0000});
        drive(1'b1, 32'hA4, 16'h0004, 1'b1, 1'b0);
        tick();
        tick();
        check("full_hold_stall", {47'd0, stall_o}, 48'd1);
        check("full_hold_head",  {inst_o, pc_o},   {32'hA0, 16'h0000});

        // drain in order
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", {inst_o, pc_o}, {32'hA0 + 32'(i), 16'(i)});
            tick();
        end
        check("drain_empty", {47'd0, v_o}, 48'd0);

        // six words with one-cycle pop lag, pointers wrap
        drive(1'b1, 32'hC0, 16'h0100, 1'b1, 1'b0);
        tick();
        for (int i = 1; i < 6; i++) begin
            drive(1'b1, 32'hC0 + i, 16'h0100 + 16'(i), 1'b0, 1'b0);
            check("wrap_head", {inst_o, pc_o}, {32'hC0 + 32'(i - 1), 16'h0100 + 16'(i - 1)});
            tick();
        end
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("wrap_last", {inst_o, pc_o}, {32'hC5, 16'h0105});
        tick();
        check("wrap_empty", {47'd0, v_o}, 48'd0);

        // simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hD0 + i, 16'h0200 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'hD2 + i, 16'h0202 + 16'(i), 1'b0, 1'b0);
            check("pp_head",  {inst_o, pc_o},   {32'hD0 + 32'(i), 16'h0200 + 16'(i)});
            check("pp_stall", {47'd0, stall_o}, 48'd0);
            tick();
        end

        // third entry, then flush with BB offered
        drive(1'b1, 32'hD7, 16'h0207, 1'b1, 1'b0);
        tick();
        check("pre_flush_head", {inst_o, pc_o}, {32'hD5, 16'h0205});
        drive(1'b1, 32'hBB, 16'h00BB, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("flush_v",     {47'd0, v_o},     48'd0);
        check("flush_stall", {47'd0, stall_o}, 48'd0);
        tick();
        check("flush_no_bb", {47'd0, v_o}, 48'd0);
        drive(1'b1, 32'h12, 16'h0012, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        check("post_flush_head", {inst_o, pc_o}, {32'h12, 16'h0012});

        // flush while holding one entry clears it; flush while empty is invisible
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
        tick();
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        check("flush_empty_v", {47'd0, v_o}, 48'd0);

        // async reset with full queue, mid-cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hE0 + i, 16'h0300 + 16'(i), 1'b1, 1'b0);
            tick();
        end
        check("pre_rst_stall", {47'd0, stall_o}, 48'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_v",     {47'd0, v_o},     48'd0);
        check("arst_stall", {47'd0, stall_o}, 48'd0);
        check("arst_head",  {inst_o, pc_o},   48'd0);
        tick();
        reset = 1'b1;
        drive(1'b1, 32'hF0, 16'h0400, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        check("after_rst_head", {inst_o, pc_o}, {32'hF0, 16'h0400});
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
